// File: rtl/glb_seq_pkg.sv
// Shared types and helpers for the global-buffer job sequencer.
package glb_seq_pkg;

    localparam int BUFFER_SIZE_DEF = 512;
    localparam int NUM_COL_DEF     = 8;
    localparam int AW              = $clog2(BUFFER_SIZE_DEF);
    localparam int IDW             = $clog2(NUM_COL_DEF) + 1;

    typedef enum logic [2:0] {
        WAIT_RST,
        IDLE,
        LOAD_FLTR,
        LOAD_IFMAP,
        DRAIN_FLTR,
        DRAIN_IFMAP,
        DONE
    } glb_seq_state_e;

    function automatic logic [31:0] sat_len(input logic [31:0] len, input logic [31:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/glb_seq_beat_cnt.sv
// Down-counter of remaining beats in the current phase; reloaded at every phase change.
module glb_seq_beat_cnt #(
    parameter int W = 10
) (
    input  logic         bus_clk,
    input  logic         rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/glb_seq_ctrl.sv
// Job sequencer: loads filter then ifmap words into the global buffer, then drains both to the PE array.
// Optional performance counters are enabled with GLB_SEQ_PERF_EN.
module glb_seq_ctrl
    import glb_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_COL     = NUM_COL_DEF,
    parameter int BUFFER_SIZE = BUFFER_SIZE_DEF
) (
    input  logic                                      bus_clk,
    input  logic                                      rstn,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [$clog2(BUFFER_SIZE):0]              cfg_fltr_len,
    input  logic [$clog2(BUFFER_SIZE):0]              cfg_ifmap_len,
    input  logic [7:0]                                cfg_kernel_size,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    input  logic [DATA_WIDTH+$clog2(NUM_COL):0]       s_data,
    input  logic                                      pe_ready,
    input  logic                                      glb_ram_rst_busy,
    input  logic                                      glb_full,
    output logic                                      glb_load_ifmap,
    output logic                                      glb_load_fltr,
    output logic [$clog2(BUFFER_SIZE)-1:0]            glb_addr_in,
    output logic [$clog2(BUFFER_SIZE)-1:0]            glb_fltr_addr_in,
    output logic [DATA_WIDTH+$clog2(NUM_COL):0]       glb_data_in,
    output logic [DATA_WIDTH-1:0]                     glb_fltr_data_in,
    output logic [7:0]                                glb_kernel_size,
    output logic                                      glb_start,
    output logic                                      glb_flush_kernel,
    output logic                                      glb_flush_tag,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      err_overflow
`ifdef GLB_SEQ_PERF_EN
    ,
    output logic [31:0]                               perf_stall_cycles,
    output logic [31:0]                               perf_job_cycles
`endif
);

    localparam int LAW = $clog2(BUFFER_SIZE);
    localparam int LW  = LAW + 1;
    localparam int SW  = DATA_WIDTH + $clog2(NUM_COL) + 1;
    localparam logic [31:0] MAX_LEN = 32'(BUFFER_SIZE);

    glb_seq_state_e r_state, w_state_next;

    logic [LW-1:0]         r_fltr_len, r_ifmap_len;
    logic [LW-1:0]         w_fltr_sat, w_ifmap_sat;
    logic [LAW-1:0]        r_wfl, r_wif;
    logic [7:0]            r_kernel_size;
    logic                  r_load_fltr, r_load_ifmap;
    logic [LAW-1:0]        r_fltr_addr, r_ifmap_addr;
    logic [DATA_WIDTH-1:0] r_fltr_data;
    logic [SW-1:0]         r_ifmap_data;
    logic                  r_err_overflow;

    logic          w_cfg_hs, w_fl_wr, w_if_wr, w_beat;
    logic          w_cnt_load, w_cnt_last;
    logic [LW-1:0] w_cnt_load_val;

    assign w_fltr_sat  = LW'(sat_len(32'(cfg_fltr_len), MAX_LEN));
    assign w_ifmap_sat = LW'(sat_len(32'(cfg_ifmap_len), MAX_LEN));
    assign w_cfg_hs    = (r_state == IDLE) && cfg_valid;
    assign w_fl_wr     = (r_state == LOAD_FLTR) && s_valid;
    assign w_if_wr     = (r_state == LOAD_IFMAP) && s_valid && !glb_full;

    // Each phase end picks the next non-empty phase directly, so empty phases cost no cycle.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_load       = 1'b0;
        w_cnt_load_val   = '0;
        w_beat           = 1'b0;
        cfg_ready        = 1'b0;
        s_ready          = 1'b0;
        glb_flush_kernel = 1'b0;
        glb_start        = 1'b0;
        glb_flush_tag    = 1'b0;
        case (r_state)
            WAIT_RST: begin
                if (!glb_ram_rst_busy) w_state_next = IDLE;
            end
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_cnt_load = 1'b1;
                    if (w_fltr_sat != '0) begin
                        w_state_next   = LOAD_FLTR;
                        w_cnt_load_val = w_fltr_sat;
                    end else if (w_ifmap_sat != '0) begin
                        w_state_next   = LOAD_IFMAP;
                        w_cnt_load_val = w_ifmap_sat;
                    end else begin
                        w_state_next   = DONE;
                    end
                end
            end
            LOAD_FLTR: begin
                s_ready = 1'b1;
                w_beat  = w_fl_wr;
                if (w_fl_wr && w_cnt_last) begin
                    w_cnt_load = 1'b1;
                    if (r_ifmap_len != '0) begin
                        w_state_next   = LOAD_IFMAP;
                        w_cnt_load_val = r_ifmap_len;
                    end else begin
                        w_state_next   = DRAIN_FLTR;
                        w_cnt_load_val = r_fltr_len;
                    end
                end
            end
            LOAD_IFMAP: begin
                s_ready = !glb_full;
                w_beat  = w_if_wr;
                if (w_if_wr && w_cnt_last) begin
                    w_cnt_load = 1'b1;
                    if (r_fltr_len != '0) begin
                        w_state_next   = DRAIN_FLTR;
                        w_cnt_load_val = r_fltr_len;
                    end else begin
                        w_state_next   = DRAIN_IFMAP;
                        w_cnt_load_val = r_ifmap_len;
                    end
                end
            end
            DRAIN_FLTR: begin
                glb_flush_kernel = pe_ready;
                w_beat           = pe_ready;
                if (pe_ready && w_cnt_last) begin
                    w_cnt_load = 1'b1;
                    if (r_ifmap_len != '0) begin
                        w_state_next   = DRAIN_IFMAP;
                        w_cnt_load_val = r_ifmap_len;
                    end else begin
                        w_state_next   = DONE;
                    end
                end
            end
            DRAIN_IFMAP: begin
                glb_start     = pe_ready;
                glb_flush_tag = pe_ready;
                w_beat        = pe_ready;
                if (pe_ready && w_cnt_last) w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = WAIT_RST;
            end
        endcase
    end

    glb_seq_beat_cnt #(
        .W(LW)
    ) u_beat_cnt (
        .bus_clk    (bus_clk),
        .rstn       (rstn),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_beat),
        .o_last     (w_cnt_last)
    );

    // Write pointers free-run across jobs to stay aligned with the buffer's read pointers.
    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= WAIT_RST;
            r_fltr_len     <= '0;
            r_ifmap_len    <= '0;
            r_kernel_size  <= '0;
            r_wfl          <= '0;
            r_wif          <= '0;
            r_load_fltr    <= 1'b0;
            r_load_ifmap   <= 1'b0;
            r_fltr_addr    <= '0;
            r_ifmap_addr   <= '0;
            r_fltr_data    <= '0;
            r_ifmap_data   <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_load_fltr  <= w_fl_wr;
            r_load_ifmap <= w_if_wr;
            if (w_cfg_hs) begin
                r_fltr_len    <= w_fltr_sat;
                r_ifmap_len   <= w_ifmap_sat;
                r_kernel_size <= cfg_kernel_size;
            end
            if (w_fl_wr) begin
                r_fltr_addr <= r_wfl;
                r_fltr_data <= s_data[DATA_WIDTH-1:0];
                r_wfl       <= (r_wfl == LAW'(BUFFER_SIZE - 1)) ? '0 : r_wfl + 1'b1;
            end
            if (w_if_wr) begin
                r_ifmap_addr <= r_wif;
                r_ifmap_data <= s_data;
                r_wif        <= (r_wif == LAW'(BUFFER_SIZE - 1)) ? '0 : r_wif + 1'b1;
            end
            if ((r_state == LOAD_IFMAP) && s_valid && glb_full) r_err_overflow <= 1'b1;
        end
    end

    assign glb_load_fltr    = r_load_fltr;
    assign glb_load_ifmap   = r_load_ifmap;
    assign glb_fltr_addr_in = r_fltr_addr;
    assign glb_addr_in      = r_ifmap_addr;
    assign glb_fltr_data_in = r_fltr_data;
    assign glb_data_in      = r_ifmap_data;
    assign glb_kernel_size  = r_kernel_size;
    assign err_overflow     = r_err_overflow;
    assign busy             = (r_state != IDLE) && (r_state != WAIT_RST);
    assign done             = (r_state == DONE);

`ifdef GLB_SEQ_PERF_EN
    logic [31:0] r_perf_stall, r_perf_job;

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_stall <= '0;
            r_perf_job   <= '0;
        end else if (w_cfg_hs) begin
            r_perf_stall <= '0;
            r_perf_job   <= '0;
        end else begin
            if (((r_state == DRAIN_FLTR) || (r_state == DRAIN_IFMAP)) && !pe_ready && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 1'b1;
            if (busy && (r_perf_job != '1))
                r_perf_job <= r_perf_job + 1'b1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_job_cycles   = r_perf_job;
`endif

endmodule
